// File: rtl/packet_segmenter_pkg.sv
// Flit and identifier types shared by the NoC transmit path.
// A HEAD flit reuses the payload field to carry the global destination id.
package packet_segmenter_pkg;

   localparam int MAX_FLIT_DEF   = 8;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int NODE_ID_W      = 4;
   localparam int PACKET_ID_W    = 3;
   localparam int FLIT_NUM_W     = $clog2(MAX_FLIT_DEF + 1);

   typedef logic [NODE_ID_W-1:0]      node_id_t;
   typedef logic [PACKET_ID_W-1:0]    packet_id_t;
   typedef logic [FLIT_NUM_W-1:0]     flit_num_t;
   typedef logic [DATA_WIDTH_DEF-1:0] payload_data_t;

   typedef enum logic [1:0] {
      HEAD = 2'd0,
      BODY = 2'd1,
      TAIL = 2'd2
   } flittype_t;

   typedef struct packed {
      packet_id_t packet_id;
      flit_num_t  flit_num;
   } flit_id_t;

   typedef struct packed {
      flittype_t flittype;
      flit_id_t  flit_id;
      node_id_t  src_id;
   } header_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-NODE_ID_W-1:0] rsvd;
      node_id_t                            global_dst_id;
   } head_payload_t;

   typedef union packed {
      payload_data_t data;
      head_payload_t hdr;
   } payload_t;

   typedef struct packed {
      header_t  header;
      payload_t payload;
   } flit_t;

endpackage

// File: rtl/packet_segmenter.sv
// Store-and-forward segmenter: buffers one packet of core words, then emits
// HEAD, BODY..., TAIL flits toward the router with a registered output stage.
module packet_segmenter
   import packet_segmenter_pkg::*;
#(
   parameter int MAX_NUM_OF_FLIT = MAX_FLIT_DEF,
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
   input  logic                  nocclk,
   input  logic                  rst_n,
   input  node_id_t              this_node_id,
   input  node_id_t              in_dst_id,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output flit_t                 out_flit,
   output logic                  out_flit_valid,
   input  logic                  out_flit_ready,
   output logic                  busy,
   output logic                  packet_sent,
   output logic                  err_overflow
);

   localparam int CAP   = MAX_NUM_OF_FLIT - 1;
   localparam int CNT_W = $clog2(MAX_NUM_OF_FLIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SEND_HEAD,
      S_SEND_DATA
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  word_cnt_reg, cnt_after;
   logic [CNT_W-1:0]  rd_idx_reg, rd_idx_next;
   payload_data_t     payload_mem [CAP];
   node_id_t          dst_reg;
   packet_id_t        pkt_id_reg;
   logic              overflow_reg;
   flit_t             out_flit_reg, out_flit_next;
   logic              out_valid_reg, out_valid_next;
   logic              packet_sent_reg, err_overflow_reg;

   logic in_hs, out_hs, tail_hs, mem_full;

   assign in_ready = (state_reg == S_IDLE) || (state_reg == S_COLLECT);
   assign in_hs    = in_valid & in_ready;
   assign out_hs   = out_valid_reg & out_flit_ready;
   assign tail_hs  = out_hs && (state_reg == S_SEND_DATA) &&
                     (out_flit_reg.header.flittype == TAIL);
   assign mem_full  = (word_cnt_reg == CNT_W'(CAP));
   assign cnt_after = mem_full ? word_cnt_reg : word_cnt_reg + 1'b1;

   assign out_flit       = out_flit_reg;
   assign out_flit_valid = out_valid_reg;
   assign busy           = (state_reg != S_IDLE);
   assign packet_sent    = packet_sent_reg;
   assign err_overflow   = err_overflow_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:      if (in_hs) state_next = in_last ? S_SEND_HEAD : S_COLLECT;
         S_COLLECT:   if (in_hs && in_last) state_next = S_SEND_HEAD;
         S_SEND_HEAD: if (out_hs) state_next = S_SEND_DATA;
         S_SEND_DATA: if (tail_hs) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // Next flit is loaded only when the current one is consumed, so the
   // registered output holds steady under backpressure.
   always_comb begin
      out_flit_next  = out_flit_reg;
      out_valid_next = out_valid_reg;
      rd_idx_next    = rd_idx_reg;
      if (in_hs && in_last) begin
         out_valid_next                            = 1'b1;
         out_flit_next                             = '0;
         out_flit_next.header.flittype             = HEAD;
         out_flit_next.header.flit_id.packet_id    = pkt_id_reg;
         out_flit_next.header.flit_id.flit_num     = FLIT_NUM_W'(cnt_after) + FLIT_NUM_W'(1);
         out_flit_next.header.src_id               = this_node_id;
         out_flit_next.payload.hdr.global_dst_id   = (state_reg == S_IDLE) ? in_dst_id : dst_reg;
         rd_idx_next                               = '0;
      end else if (tail_hs) begin
         out_valid_next = 1'b0;
         out_flit_next  = '0;
      end else if (out_hs) begin
         out_flit_next.header.flittype =
            (rd_idx_reg == word_cnt_reg - 1'b1) ? TAIL : BODY;
         out_flit_next.payload.data    = payload_mem[rd_idx_reg];
         rd_idx_next                   = rd_idx_reg + 1'b1;
      end
   end

   always_ff @(posedge nocclk) begin
      if (in_hs && !mem_full)
         payload_mem[word_cnt_reg] <= in_data;
   end

   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         word_cnt_reg     <= '0;
         rd_idx_reg       <= '0;
         dst_reg          <= '0;
         pkt_id_reg       <= '0;
         overflow_reg     <= 1'b0;
         out_flit_reg     <= '0;
         out_valid_reg    <= 1'b0;
         packet_sent_reg  <= 1'b0;
         err_overflow_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         out_flit_reg     <= out_flit_next;
         out_valid_reg    <= out_valid_next;
         rd_idx_reg       <= rd_idx_next;
         packet_sent_reg  <= tail_hs;
         err_overflow_reg <= in_hs & in_last & (overflow_reg | mem_full);
         if (in_hs) begin
            if (state_reg == S_IDLE)
               dst_reg <= in_dst_id;
            // Words past capacity are dropped but still count toward the error.
            if (mem_full)
               overflow_reg <= 1'b1;
            else
               word_cnt_reg <= word_cnt_reg + 1'b1;
         end
         if (tail_hs) begin
            pkt_id_reg   <= pkt_id_reg + 1'b1;
            word_cnt_reg <= '0;
            overflow_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_packet_segmenter.sv
// Directed bench for packet_segmenter: table of packets plus hand-written
// backpressure, mid-packet reset and packet-id wrap sequences.
module tb_packet_segmenter;
   import packet_segmenter_pkg::*;

   localparam node_id_t SELF_ID = 4'hA;
   localparam int       CAPW    = MAX_FLIT_DEF - 1;

   logic          nocclk = 1'b0;
   logic          rst_n = 1'b0;
   node_id_t      this_node_id = SELF_ID;
   node_id_t      in_dst_id = '0;
   logic [31:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   flit_t         out_flit;
   logic          out_flit_valid;
   logic          out_flit_ready = 1'b1;
   logic          busy, packet_sent, err_overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sent_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      flit_t flit;
      int    cyc;
      logic  in_ready;
   } rec_t;
   rec_t recq[$];

   typedef struct {
      int       nwords;
      node_id_t dst;
      int       exp_fnum;
      bit       exp_err;
   } vec_t;
   vec_t vecs[6];

   packet_segmenter dut (
      .nocclk         (nocclk),
      .rst_n          (rst_n),
      .this_node_id   (this_node_id),
      .in_dst_id      (in_dst_id),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_flit       (out_flit),
      .out_flit_valid (out_flit_valid),
      .out_flit_ready (out_flit_ready),
      .busy           (busy),
      .packet_sent    (packet_sent),
      .err_overflow   (err_overflow)
   );

   always #5 nocclk = ~nocclk;

   always @(posedge nocclk) cyc <= cyc + 1;

   // Flits are captured mid-cycle when valid and ready, i.e. just before the handshake edge.
   always @(negedge nocclk) begin
      if (out_flit_valid && out_flit_ready)
         recq.push_back('{flit: out_flit, cyc: cyc, in_ready: in_ready});
      if (packet_sent) sent_cnt <= sent_cnt + 1;
      if (err_overflow) err_cnt <= err_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic payload_data_t word_val(input int tag, input int k);
      return 32'hA500_0000 + 32'(tag * 256 + k);
   endfunction

   function automatic flit_t mk_head(input packet_id_t id, input flit_num_t fn, input node_id_t dst);
      flit_t f;
      f = '0;
      f.header.flittype             = HEAD;
      f.header.flit_id.packet_id    = id;
      f.header.flit_id.flit_num     = fn;
      f.header.src_id               = SELF_ID;
      f.payload.hdr.global_dst_id   = dst;
      return f;
   endfunction

   function automatic flit_t mk_data(input packet_id_t id, input flit_num_t fn,
                                     input flittype_t t, input payload_data_t d);
      flit_t f;
      f = '0;
      f.header.flittype          = t;
      f.header.flit_id.packet_id = id;
      f.header.flit_id.flit_num  = fn;
      f.header.src_id            = SELF_ID;
      f.payload.data             = d;
      return f;
   endfunction

   // Called just after a rising edge; returns just after the last word's handshake edge.
   task automatic send_packet(input int n, input node_id_t dst, input int tag);
      bit acc;
      for (int k = 0; k < n; k++) begin
         in_valid  = 1'b1;
         in_data   = word_val(tag, k);
         in_last   = (k == n - 1);
         in_dst_id = (k == 0) ? dst : ~dst;
         acc = 1'b0;
         for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge nocclk);
            acc = in_ready;
            @(posedge nocclk);
            #1;
         end
         if (!acc) check("in_accept_timeout", 64'(0), 64'(1));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_packet(input int fnum, input node_id_t dst, input int tag,
                               input packet_id_t id, input bit exp_err, input bit chk_gap,
                               input int q0, input int s0, input int e0);
      int    nd, got;
      flit_t exp;
      nd = fnum - 1;
      for (int c = 0; c < 60 && sent_cnt == s0; c++) @(negedge nocclk);
      if (sent_cnt == s0) check("tail_timeout", 64'(0), 64'(1));
      @(negedge nocclk);
      got = recq.size() - q0;
      check("flit_count", 64'(got), 64'(fnum));
      for (int f = 0; f < got && f < fnum; f++) begin
         if (f == 0) exp = mk_head(id, flit_num_t'(fnum), dst);
         else        exp = mk_data(id, flit_num_t'(fnum), (f == nd) ? TAIL : BODY, word_val(tag, f - 1));
         check($sformatf("flit%0d", f), 64'(recq[q0+f].flit), 64'(exp));
         check("in_ready_during_send", 64'(recq[q0+f].in_ready), 64'(0));
         if (chk_gap && f > 0)
            check("flit_gap", 64'(recq[q0+f].cyc - recq[q0+f-1].cyc), 64'(1));
      end
      check("packet_sent_pulses", 64'(sent_cnt - s0), 64'(1));
      check("err_overflow_pulses", 64'(err_cnt - e0), 64'(exp_err));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_in_ready", 64'(in_ready), 64'(1));
      check("idle_valid", 64'(out_flit_valid), 64'(0));
      $display("packet id=%0d words->flits=%0d dst=%0d err=%0d checks=%0d errors=%0d",
               id, got, dst, err_cnt - e0, checks, errors);
      @(posedge nocclk);
      #1;
   endtask

   task automatic run_packet(input int n, input node_id_t dst, input int tag, input int fnum,
                             input packet_id_t id, input bit exp_err);
      int q0, s0, e0;
      q0 = recq.size();
      s0 = sent_cnt;
      e0 = err_cnt;
      send_packet(n, dst, tag);
      @(negedge nocclk);
      check("head_latency", 64'(out_flit_valid), 64'(1));
      check_packet(fnum, dst, tag, id, exp_err, 1'b1, q0, s0, e0);
   endtask

   initial begin
      int    q0, s0, e0;
      flit_t exp_b0;

      vecs[0] = '{nwords: 3,  dst: 4'd5, exp_fnum: 4, exp_err: 1'b0};
      vecs[1] = '{nwords: 1,  dst: 4'd7, exp_fnum: 2, exp_err: 1'b0};
      vecs[2] = '{nwords: 10, dst: 4'd3, exp_fnum: 8, exp_err: 1'b1};
      vecs[3] = '{nwords: 7,  dst: 4'd2, exp_fnum: 8, exp_err: 1'b0};
      vecs[4] = '{nwords: 8,  dst: 4'd9, exp_fnum: 8, exp_err: 1'b1};
      vecs[5] = '{nwords: 2,  dst: 4'd1, exp_fnum: 3, exp_err: 1'b0};

      repeat (2) @(posedge nocclk);
      #1;
      check("rst_out_flit", 64'(out_flit), 64'(0));
      check("rst_valid", 64'(out_flit_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pulses", 64'({packet_sent, err_overflow}), 64'(0));
      @(negedge nocclk);
      rst_n = 1'b1;
      @(posedge nocclk);
      #1;

      for (int i = 0; i < 6; i++)
         run_packet(vecs[i].nwords, vecs[i].dst, i, vecs[i].exp_fnum, packet_id_t'(i), vecs[i].exp_err);

      // Backpressure: hold ready low for three cycles while the first BODY is presented.
      q0 = recq.size();
      s0 = sent_cnt;
      e0 = err_cnt;
      send_packet(4, 4'd6, 20);
      @(negedge nocclk);
      check("stall_head_latency", 64'(out_flit_valid), 64'(1));
      @(posedge nocclk);
      #1;
      out_flit_ready = 1'b0;
      exp_b0 = mk_data(3'd6, 4'd5, BODY, word_val(20, 0));
      for (int c = 0; c < 3; c++) begin
         @(negedge nocclk);
         check("stall_flit", 64'(out_flit), 64'(exp_b0));
         check("stall_valid", 64'(out_flit_valid), 64'(1));
      end
      @(posedge nocclk);
      #1;
      out_flit_ready = 1'b1;
      check_packet(5, 4'd6, 20, 3'd6, 1'b0, 1'b0, q0, s0, e0);

      // Reset in the middle of the data phase of packet id 7.
      s0 = sent_cnt;
      send_packet(5, 4'd8, 30);
      @(posedge nocclk);
      @(posedge nocclk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_flit_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_out_flit", 64'(out_flit), 64'(0));
      @(negedge nocclk);
      rst_n = 1'b1;
      repeat (3) @(negedge nocclk);
      check("midrst_no_tail", 64'(sent_cnt - s0), 64'(0));
      $display("midreset packet discarded checks=%0d errors=%0d", checks, errors);
      @(posedge nocclk);
      #1;

      // Single-word packets from id 0 after reset through one full wrap of the id.
      for (int p = 0; p < 9; p++)
         run_packet(1, node_id_t'(p), 40 + p, 2, packet_id_t'(p % 8), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
